// File: rtl/gcd_core.sv
// gcd_core: iterative GCD of two unsigned operands by repeated subtraction.
// One request at a time. The result is held in gcd_o, and valid_o pulses for one cycle.
module gcd_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,   // asynchronous, active low
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] gcd_o,
    output logic             valid_o
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic             valid_q, valid_d;

    // Next-state logic: load in idle, apply one reduction rule per cycle in calc.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        gcd_d   = gcd_q;
        valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                // First match wins; the larger operand is always the minuend.
                if (a_q == '0) begin
                    gcd_d   = b_q;
                    valid_d = 1'b1;
                    state_d = StDone;
                end else if (b_q == '0 || a_q == b_q) begin
                    gcd_d   = a_q;
                    valid_d = 1'b1;
                    state_d = StDone;
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            gcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gcd_q   <= gcd_d;
            valid_q <= valid_d;
        end
    end

    assign gcd_o   = gcd_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_gcd_core.sv
// Self-checking bench for gcd_core: directed table, corner sequences, random requests.
module tb_gcd_core;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       valid_i;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic [7:0] gcd_o;
    logic       valid_o;

    int vectors = 0;
    int miscompares = 0;

    gcd_core #(.WIDTH(8)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .gcd_o   (gcd_o),
        .valid_o (valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int a;
        int b;
        int exp_gcd;
        int exp_lat;
    } vec_t;

    vec_t tbl[10];

    // Euclid by division.
    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Number of subtraction steps, counted via quotients rather than single steps.
    // Each quotient q contributes q subtractions, or q-1 if it divides exactly
    // (the last one is replaced by the equality stop).
    function automatic int ref_lat(input int a, input int b);
        int steps = 0;
        while (a != 0 && b != 0 && a != b) begin
            if (a > b) begin
                if (a % b == 0) begin steps += a / b - 1; a = b; end
                else begin steps += a / b; a = a % b; end
            end else begin
                if (b % a == 0) begin steps += b / a - 1; b = a; end
                else begin steps += b / a; b = b % a; end
            end
        end
        return steps + 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one request and check result, latency, pulse width and hold.
    // With inject set, a (9,6) strobe is pulsed during the calculation.
    task automatic run_req(input int a, input int b, input int exp_g, input int exp_lat,
                           input bit inject);
        int lat;
        bit seen;
        @(negedge clk_i);
        valid_i = 1'b1;
        a_i = 8'(a);
        b_i = 8'(b);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        a_i = 8'hxx;
        b_i = 8'hxx;
        seen = 1'b0;
        lat = 0;
        for (int i = 1; i <= 300; i++) begin
            if (inject && i == 1) begin
                valid_i = 1'b1;
                a_i = 8'd9;
                b_i = 8'd6;
            end else begin
                valid_i = 1'b0;
            end
            @(posedge clk_i);
            #1;
            if (valid_o) begin
                seen = 1'b1;
                lat = i;
                break;
            end
        end
        valid_i = 1'b0;
        if (!seen) begin
            check($sformatf("timeout(%0d,%0d)", a, b), 0, 1);
        end else begin
            check($sformatf("gcd(%0d,%0d)", a, b), int'(gcd_o), exp_g);
            check($sformatf("lat(%0d,%0d)", a, b), lat, exp_lat);
            @(posedge clk_i);
            #1;
            check($sformatf("pulse_width(%0d,%0d)", a, b), int'(valid_o), 0);
            check($sformatf("hold(%0d,%0d)", a, b), int'(gcd_o), exp_g);
        end
    endtask

    initial begin
        int ra, rb;
        tbl[0] = '{48, 18, 6, 5};
        tbl[1] = '{60, 84, 12, 5};
        tbl[2] = '{0, 5, 5, 1};
        tbl[3] = '{5, 0, 5, 1};
        tbl[4] = '{0, 0, 0, 1};
        tbl[5] = '{255, 255, 255, 1};
        tbl[6] = '{7, 13, 1, 8};
        tbl[7] = '{17, 23, 1, 9};
        tbl[8] = '{255, 1, 1, 255};
        tbl[9] = '{128, 64, 64, 2};

        reset_i = 1'b0;
        valid_i = 1'b0;
        a_i = '0;
        b_i = '0;
        #1;
        check("reset_gcd", int'(gcd_o), 0);
        check("reset_valid", int'(valid_o), 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;

        // Directed table.
        foreach (tbl[i]) run_req(tbl[i].a, tbl[i].b, tbl[i].exp_gcd, tbl[i].exp_lat, 1'b0);

        // Strobe during calculation is ignored; result holds through idle.
        run_req(100, 75, 25, 4, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i);
            #1;
            check("no_extra_pulse", int'(valid_o), 0);
        end
        check("hold_idle", int'(gcd_o), 25);

        // Reset mid-calculation aborts without a pulse.
        @(negedge clk_i);
        valid_i = 1'b1;
        a_i = 8'd255;
        b_i = 8'd1;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (10) @(negedge clk_i);
        #2;
        reset_i = 1'b0;
        #1;
        check("midreset_gcd", int'(gcd_o), 0);
        check("midreset_valid", int'(valid_o), 0);
        @(posedge clk_i);
        #1;
        check("midreset_gcd_held", int'(gcd_o), 0);
        @(negedge clk_i);
        reset_i = 1'b1;
        begin
            bit pulsed = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(posedge clk_i);
                #1;
                if (valid_o) pulsed = 1'b1;
            end
            check("no_pulse_after_abort", int'(pulsed), 0);
        end
        run_req(48, 18, 6, 5, 1'b0);

        // Random requests against the reference model.
        for (int n = 0; n < 150; n++) begin
            ra = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            run_req(ra, rb, ref_gcd(ra, rb), ref_lat(ra, rb), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
